// File: rtl/lsu_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl_pkg
// Purpose  : Shared constants for the load/store controller. It holds the
//            RV32I funct3 codes for loads and stores, and the 2-bit FSM
//            state encodings. It also provides a helper that classifies an
//            access as faulting, which covers misalignment and illegal
//            funct3 values.
// Revision : 1.0  initial release
// ============================================================================
package lsu_mem_ctrl_pkg;

    // RV32I load funct3 codes
    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    // RV32I store funct3 codes
    localparam logic [2:0] c_F3_SB  = 3'b000;
    localparam logic [2:0] c_F3_SH  = 3'b001;
    localparam logic [2:0] c_F3_SW  = 3'b010;

    // Controller state encodings
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_WRITE = 2'd2;
    localparam logic [1:0] c_ST_RESP  = 2'd3;

    // An access faults when:
    //   - the funct3 value is not a legal code for the direction, or
    //   - the access is misaligned (halfword on an odd byte, or word not on
    //     a word boundary).
    function automatic logic access_fault(
        input logic       we,
        input logic [2:0] funct3,
        input logic [1:0] lane
    );
        logic v_fault;
        v_fault = 1'b0;
        if (we) begin
            case (funct3)
                c_F3_SB: v_fault = 1'b0;
                c_F3_SH: v_fault = lane[0];
                c_F3_SW: v_fault = |lane;
                default: v_fault = 1'b1;
            endcase
        end else begin
            case (funct3)
                c_F3_LB, c_F3_LBU: v_fault = 1'b0;
                c_F3_LH, c_F3_LHU: v_fault = lane[0];
                c_F3_LW:           v_fault = |lane;
                default:           v_fault = 1'b1;
            endcase
        end
        return v_fault;
    endfunction

endpackage : lsu_mem_ctrl_pkg
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Purpose  : Purely combinational byte-lane steering for the load/store
//            controller.
//              - Load path : picks the byte or halfword selected by the lane
//                            and sign- or zero-extends it.
//              - Store path: merges the store data into the memory word at
//                            the selected lane.
// Ports    : i_funct3       access funct3 (selects size and signedness)
//            i_lane         byte address bits [1:0]
//            i_word         current memory word
//            i_store_data   right-aligned store data
//            o_load_data    extended load result
//            o_merged       memory word with the store lane replaced
// Revision : 1.0  initial release
// ============================================================================
module lsu_lane_align
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            i_funct3,
    input  logic [1:0]            i_lane,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic [DATA_WIDTH-1:0] i_store_data,
    output logic [DATA_WIDTH-1:0] o_load_data,
    output logic [DATA_WIDTH-1:0] o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_lane)
            2'd0: w_byte = i_word[7:0];
            2'd1: w_byte = i_word[15:8];
            2'd2: w_byte = i_word[23:16];
            2'd3: w_byte = i_word[31:24];
            default: w_byte = 8'h00;
        endcase
        // Halfwords are only legal on even lanes, so lane[1] selects the half
        w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_load_data = i_word;
        case (i_funct3)
            c_F3_LB:  o_load_data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            c_F3_LBU: o_load_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            c_F3_LH:  o_load_data = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            c_F3_LHU: o_load_data = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default:  o_load_data = i_word;
        endcase
    end

    always_comb begin
        o_merged = i_word;
        case (i_funct3)
            c_F3_SB: begin
                case (i_lane)
                    2'd0: o_merged[7:0]   = i_store_data[7:0];
                    2'd1: o_merged[15:8]  = i_store_data[7:0];
                    2'd2: o_merged[23:16] = i_store_data[7:0];
                    2'd3: o_merged[31:24] = i_store_data[7:0];
                    default: o_merged = i_word;
                endcase
            end
            c_F3_SH: begin
                if (i_lane[1]) begin
                    o_merged[31:16] = i_store_data[15:0];
                end else begin
                    o_merged[15:0]  = i_store_data[15:0];
                end
            end
            default: o_merged = i_store_data;
        endcase
    end

endmodule : lsu_lane_align
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Purpose  : Load/store controller between the RV32I execute stage and a
//            word-addressed single-port data memory.
//              - Accepts one byte-addressed load or store per handshake.
//              - Sub-word loads are extracted and extended.
//              - Sub-word stores are done as read-modify-write.
//              - Misaligned or illegal accesses return a fault and never
//                touch memory.
// Ports    : clk, reset (sync, active-low)
//            i_ReqValid/o_ReqReady      request handshake
//            i_ReqWe, i_Funct3          direction and access type
//            i_ByteAddr, i_StoreData    request address and data
//            o_RspValid                 one-cycle response pulse
//            o_LoadData, o_Fault        response payload
//            o_MemAddr, o_MemDataOut    memory word address and write data
//            o_MemWrEn                  memory write enable
//            i_MemDataIn                combinational memory read data
// Revision : 1.0  initial release
// ============================================================================
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_ReqValid,
    output logic                      o_ReqReady,
    input  logic                      i_ReqWe,
    input  logic [2:0]                i_Funct3,
    input  logic [MEM_ADDR_WIDTH+1:0] i_ByteAddr,
    input  logic [DATA_WIDTH-1:0]     i_StoreData,
    output logic                      o_RspValid,
    output logic [DATA_WIDTH-1:0]     o_LoadData,
    output logic                      o_Fault,
    output logic [MEM_ADDR_WIDTH-1:0] o_MemAddr,
    output logic [DATA_WIDTH-1:0]     o_MemDataOut,
    output logic                      o_MemWrEn,
    input  logic [DATA_WIDTH-1:0]     i_MemDataIn
);

    logic [1:0]                r_state;
    logic                      r_we;
    logic [2:0]                r_funct3;
    logic [MEM_ADDR_WIDTH+1:0] r_addr;
    logic [DATA_WIDTH-1:0]     r_sdata;
    logic                      r_rsp_valid;
    logic                      r_fault;
    logic [DATA_WIDTH-1:0]     r_load_data;
    logic [DATA_WIDTH-1:0]     r_mem_data_out;
    logic                      r_mem_wr_en;

    logic                      w_req_fault;
    logic [DATA_WIDTH-1:0]     w_load_data;
    logic [DATA_WIDTH-1:0]     w_merged;

    assign w_req_fault = access_fault(i_ReqWe, i_Funct3, i_ByteAddr[1:0]);

    // Lane steering works on the live memory read data during LOAD. That is
    // the cycle in which both the load result and the RMW merge are captured.
    lsu_lane_align #(
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_lane_align (
        .i_funct3     (r_funct3),
        .i_lane       (r_addr[1:0]),
        .i_word       (i_MemDataIn),
        .i_store_data (r_sdata),
        .o_load_data  (w_load_data),
        .o_merged     (w_merged)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= c_ST_IDLE;
            r_we           <= 1'b0;
            r_funct3       <= 3'b000;
            r_addr         <= '0;
            r_sdata        <= '0;
            r_rsp_valid    <= 1'b0;
            r_fault        <= 1'b0;
            r_load_data    <= '0;
            r_mem_data_out <= '0;
            r_mem_wr_en    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    // In IDLE with reset high, ready is 1, so valid alone
                    // completes the handshake.
                    if (i_ReqValid) begin
                        r_we     <= i_ReqWe;
                        r_funct3 <= i_Funct3;
                        r_addr   <= i_ByteAddr;
                        r_sdata  <= i_StoreData;
                        if (w_req_fault) begin
                            r_state     <= c_ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_fault     <= 1'b1;
                            r_load_data <= '0;
                        end else if (i_ReqWe && (i_Funct3 == c_F3_SW)) begin
                            // A full-word store needs no read
                            r_state        <= c_ST_WRITE;
                            r_mem_wr_en    <= 1'b1;
                            r_mem_data_out <= i_StoreData;
                        end else begin
                            r_state <= c_ST_LOAD;
                        end
                    end
                end

                c_ST_LOAD: begin
                    if (r_we) begin
                        r_state        <= c_ST_WRITE;
                        r_mem_wr_en    <= 1'b1;
                        r_mem_data_out <= w_merged;
                    end else begin
                        r_state     <= c_ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_fault     <= 1'b0;
                        r_load_data <= w_load_data;
                    end
                end

                c_ST_WRITE: begin
                    r_state     <= c_ST_RESP;
                    r_mem_wr_en <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    r_fault     <= 1'b0;
                    r_load_data <= '0;
                end

                c_ST_RESP: begin
                    r_state     <= c_ST_IDLE;
                    r_rsp_valid <= 1'b0;
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign o_ReqReady   = (r_state == c_ST_IDLE) && reset;
    assign o_RspValid   = r_rsp_valid;
    assign o_Fault      = r_fault;
    assign o_LoadData   = r_load_data;
    assign o_MemAddr    = r_addr[MEM_ADDR_WIDTH+1:2];
    assign o_MemDataOut = r_mem_data_out;
    // Gating with reset means a reset landing in WRITE suppresses the write
    // on that same edge.
    assign o_MemWrEn    = r_mem_wr_en && reset;

endmodule : lsu_mem_ctrl
`default_nettype wire

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller that sits between the RV32I execute stage and the word-addressed data memory, acting as the initiator for that memory's single-port interface. It accepts one byte-addressed load or store per handshake and performs sub-word extraction with sign/zero extension. Byte and halfword stores are done as a read-modify-write sequence. Misaligned or illegal accesses produce a fault response and never touch memory.

## Interface
- MEM_ADDR_WIDTH, `_MEM_ADDR_WIDTH_, word-address width of data memory
- DATA_WIDTH, `_DATA_WIDTH_ (32), word width; only 32 supported
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- i_ReqValid  in  1  request present
- o_ReqReady  out  1  high only in IDLE and reset deasserted; a request is accepted when i_ReqValid && o_ReqReady at a rising edge
- i_ReqWe  in  1  1=store, 0=load
- i_Funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU = 000/001/010/100/101; SB/SH/SW = 000/001/010)
- i_ByteAddr  in  MEM_ADDR_WIDTH+2  byte address
- i_StoreData  in  DATA_WIDTH  store data, right-aligned
- o_RspValid  out  1  one-cycle response pulse, no backpressure
- o_LoadData  out  DATA_WIDTH  extended load result, valid with o_RspValid
- o_Fault  out  1  misaligned/illegal, valid with o_RspValid
- o_MemAddr  out  MEM_ADDR_WIDTH  word address = latched byte address >> 2
- o_MemDataOut  out  DATA_WIDTH  write data to memory
- o_MemWrEn  out  1  memory write enable
- i_MemDataIn  in  DATA_WIDTH  combinational read data from memory

## Operation
- All request fields are latched on accept. Lane = addr[1:0].
- Fault conditions:
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - load funct3 in {011,110,111}
  - store funct3 > 010
- States:
  - IDLE: on accept → RESP if fault; LOAD if load, SB or SH; WRITE if SW.
  - LOAD: capture i_MemDataIn into r_word. Load → RESP with extended result. SB/SH → WRITE.
  - WRITE: o_MemWrEn=1, then → RESP. o_MemDataOut is:
    - SW: store data
    - SB: r_word with byte lane replaced by StoreData[7:0]
    - SH: r_word with half addr[1] replaced by StoreData[15:0]
  - RESP: o_RspValid=1, then → IDLE.
- Load extraction:
  - LB: sign-extend the lane byte; LBU: zero-extend it.
  - LH: sign-extend half addr[1]; LHU: zero-extend it.
  - LW: full word.
- o_LoadData=0 on store and fault responses. It holds its value between responses.

## Timing
- Accept edge at cycle N. Responses:
  - load: RESP in N+2
  - SW: WRITE in N+1, RESP in N+2
  - SB/SH: LOAD in N+1, WRITE in N+2, RESP in N+3
  - fault: RESP in N+1
- Memory contents update at the edge ending WRITE, so a load accepted on the RESP→IDLE boundary sees the new data.
- o_ReqReady=0 in LOAD/WRITE/RESP. Requests are not queued; i_ReqValid in those states is ignored until IDLE.
- o_MemWrEn is asserted only in WRITE. It is gated by reset so no write is issued while reset is low.
- Reset (reset=0 at an edge) from any state → IDLE, aborting any in-flight request with no response. Outputs after reset:
  - o_RspValid=0, o_Fault=0, o_LoadData=0
  - o_MemAddr=0, o_MemDataOut=0, o_MemWrEn=0
  - o_ReqReady=1 once reset deasserts
- Reset asserted in WRITE: no memory write for that request.

## Structure
- Add to light_rv32i_defs.vh: funct3 constants (LB…SW) and 2-bit state encodings (IDLE, LOAD, WRITE, RESP).
- One sub-module, lsu_lane_align (combinational): lane extraction/extension for loads and lane merge for stores. The FSM and registers stay in lsu_mem_ctrl.

## Test plan
- Mem word 5 = 0x8000_F0A5:
  - LB @0x14 → RspValid at N+2, LoadData=0xFFFF_FFA5, Fault=0
  - LBU @0x15 → 0x0000_00F0
  - LH @0x16 → 0xFFFF_8000
- SB data 0x12 @0x17 on word 0x1122_3344 → WrEn only in N+2, MemDataOut=0x1222_3344, RspValid in N+3. Follow-up LW @0x14 → 0x1222_3344.
- SW 0xDEAD_BEEF @0x20 → MemAddr=8, WrEn in N+1, RspValid in N+2, LoadData=0.
- LW @0x22, SH @0x13, and load funct3=011 → RspValid at N+1 with Fault=1, WrEn never asserted, memory unchanged.
- Back-to-back: ReqValid held high for two requests → second accepted only in the cycle after the first RESP; requests presented in LOAD/WRITE are not accepted.
- Reset low during WRITE of an SH → no write; next edge state IDLE, all outputs at reset values, ReqReady=1 after reset deasserts.
